// File: rtl/harmonogram_wyswietlacza_pkg.sv
// rtl/harmonogram_wyswietlacza_pkg.sv - shared types, limits and 7-segment lookup for the display scheduler
package pakiet_wyswietlacza;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START_A = 3'd1,
      CONV_A  = 3'd2,
      START_B = 3'd3,
      CONV_B  = 3'd4,
      COMMIT  = 3'd5
   } stan_t;

   typedef logic [1:0] cyfra_t;

   localparam logic [6:0] MAX_RPM = 7'd99;

   // Segments {g,f,e,d,c,b,a}, active-low; anything outside 0..9 renders blank.
   function automatic logic [6:0] seg7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/konwerter_bcd_iter.sv
// rtl/konwerter_bcd_iter.sv - iterative binary-to-BCD converter for 0..99 by repeated subtraction of ten
module konwerter_bcd_iter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [6:0] wartosc,
   output logic       done,
   output logic [7:0] bcd
);

   logic       busy_q, busy_d;
   logic [6:0] reszta_q, reszta_d;
   logic [3:0] dziesiatki_q, dziesiatki_d;

   always_comb begin
      busy_d       = busy_q;
      reszta_d     = reszta_q;
      dziesiatki_d = dziesiatki_q;
      if (start) begin
         busy_d       = 1'b1;
         reszta_d     = wartosc;
         dziesiatki_d = 4'd0;
      end else if (busy_q) begin
         if (reszta_q >= 7'd10) begin
            reszta_d     = reszta_q - 7'd10;
            dziesiatki_d = dziesiatki_q + 4'd1;
         end else begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q       <= 1'b0;
         reszta_q     <= '0;
         dziesiatki_q <= '0;
      end else begin
         busy_q       <= busy_d;
         reszta_q     <= reszta_d;
         dziesiatki_q <= dziesiatki_d;
      end
   end

   // Done is combinational so a single-digit value finishes one cycle after start.
   assign done = busy_q && (reszta_q < 7'd10);
   assign bcd  = {dziesiatki_q, reszta_q[3:0]};

endmodule

// File: rtl/harmonogram_wyswietlacza.sv
// rtl/harmonogram_wyswietlacza.sv - shares one BCD converter between two rpm sources and scans a 4-digit display; ZERA_WIODACE_EN blanks zero tens digits
import pakiet_wyswietlacza::*;

module harmonogram_wyswietlacza #(
   parameter int REFRESH_CYCLES = 10000,
   parameter int SCAN_CYCLES    = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] rpm_zmierzone,
   input  logic [6:0] rpm_zadane,
   output logic [7:0] bcd_zmierzone,
   output logic [7:0] bcd_zadane,
   output logic       nowe_dane,
   output logic       przepelnienie,
   output logic [3:0] anody,
   output logic [6:0] segmenty
);

   localparam int RW = $clog2(REFRESH_CYCLES);
   localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

   logic [RW-1:0] odswiez_q, odswiez_d;
   logic          tick;
   logic [SW-1:0] skan_q, skan_d;
   cyfra_t        cyfra_q, cyfra_d;
   logic [3:0]    anody_q, anody_d;
   logic [6:0]    segmenty_q, segmenty_d;
   logic [3:0]    nibble;

   stan_t      stan_q;
   logic [6:0] snap_a_q, snap_b_q;
   logic       ovf_a_q, ovf_b_q;
   logic [7:0] wynik_a_q, wynik_b_q;
   logic [7:0] bcd_zm_q, bcd_za_q;
   logic       nowe_dane_q, przepelnienie_q;

   logic       konw_start, konw_done;
   logic [6:0] konw_wartosc;
   logic [7:0] konw_bcd;

   assign tick = (odswiez_q == RW'(REFRESH_CYCLES - 1));

   always_comb begin
      odswiez_d = tick ? '0 : odswiez_q + 1'b1;
      if (skan_q == SW'(SCAN_CYCLES - 1)) begin
         skan_d  = '0;
         cyfra_d = cyfra_q + 2'd1;
      end else begin
         skan_d  = skan_q + 1'b1;
         cyfra_d = cyfra_q;
      end
   end

   assign konw_start   = (stan_q == START_A) || (stan_q == START_B);
   assign konw_wartosc = (stan_q == START_B) ? snap_b_q : snap_a_q;

   konwerter_bcd_iter u_konwerter (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (konw_start),
      .wartosc (konw_wartosc),
      .done    (konw_done),
      .bcd     (konw_bcd)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stan_q          <= IDLE;
         snap_a_q        <= '0;
         snap_b_q        <= '0;
         ovf_a_q         <= 1'b0;
         ovf_b_q         <= 1'b0;
         wynik_a_q       <= '0;
         wynik_b_q       <= '0;
         bcd_zm_q        <= '0;
         bcd_za_q        <= '0;
         nowe_dane_q     <= 1'b0;
         przepelnienie_q <= 1'b0;
      end else begin
         nowe_dane_q <= 1'b0;
         case (stan_q)
            IDLE: begin
               if (tick) begin
                  snap_a_q <= (rpm_zmierzone > MAX_RPM) ? MAX_RPM : rpm_zmierzone;
                  snap_b_q <= (rpm_zadane > MAX_RPM) ? MAX_RPM : rpm_zadane;
                  ovf_a_q  <= (rpm_zmierzone > MAX_RPM);
                  ovf_b_q  <= (rpm_zadane > MAX_RPM);
                  stan_q   <= START_A;
               end
            end
            START_A: stan_q <= CONV_A;
            CONV_A: begin
               if (konw_done) begin
                  wynik_a_q <= konw_bcd;
                  stan_q    <= START_B;
               end
            end
            START_B: stan_q <= CONV_B;
            CONV_B: begin
               if (konw_done) begin
                  wynik_b_q <= konw_bcd;
                  stan_q    <= COMMIT;
               end
            end
            COMMIT: begin
               bcd_zm_q        <= wynik_a_q;
               bcd_za_q        <= wynik_b_q;
               przepelnienie_q <= ovf_a_q | ovf_b_q;
               nowe_dane_q     <= 1'b1;
               stan_q          <= IDLE;
            end
            default: stan_q <= IDLE;
         endcase
      end
   end

   // Display reads only the committed pair, so a round in progress is never visible.
   always_comb begin
      case (cyfra_q)
         2'd0:    nibble = bcd_zm_q[3:0];
         2'd1:    nibble = bcd_zm_q[7:4];
         2'd2:    nibble = bcd_za_q[3:0];
         default: nibble = bcd_za_q[7:4];
      endcase
      anody_d    = ~(4'b0001 << cyfra_q);
      segmenty_d = seg7(nibble);
`ifdef ZERA_WIODACE_EN
      if (cyfra_q[0] && (nibble == 4'd0)) anody_d = 4'b1111;
`else
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         odswiez_q  <= '0;
         skan_q     <= '0;
         cyfra_q    <= '0;
         anody_q    <= 4'b1111;
         segmenty_q <= 7'h7F;
      end else begin
         odswiez_q  <= odswiez_d;
         skan_q     <= skan_d;
         cyfra_q    <= cyfra_d;
         anody_q    <= anody_d;
         segmenty_q <= segmenty_d;
      end
   end

   assign bcd_zmierzone = bcd_zm_q;
   assign bcd_zadane    = bcd_za_q;
   assign nowe_dane     = nowe_dane_q;
   assign przepelnienie = przepelnienie_q;
   assign anody         = anody_q;
   assign segmenty      = segmenty_q;

endmodule
